posit_pack: RTL and testbench

- Pipelined posit encoder: converts sign, regime value k, exponent and fraction fields into one WORD_SIZE-bit posit word.
- Inverse of the posit field-extraction stage. Sits at the output of the posit arithmetic datapath (add/mul), after normalisation.
- Performs regime run construction, round-to-nearest-even, saturation and two's-complement negation.
- Three-stage pipeline with valid/ready handshake on both sides.

---
 rtl/posit_pack.sv | 130 +++++++++++++
 tb/tb_posit_pack.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/posit_pack.sv
// posit_pack: three-stage posit encoder (regime build, round-to-nearest-even,
// sign/specials). A single global enable stalls the whole pipe when the
// output beat is not taken.
module posit_pack #(
    parameter int WORD_SIZE = 32,
    parameter int RS        = 5,
    parameter int ES        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic                    in_zero,
    input  logic                    in_nar,
    input  logic [RS:0]             in_regime,
    input  logic [ES-1:0]           in_exp,
    input  logic [WORD_SIZE-ES-1:0] in_frac,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_SIZE-1:0]    out_posit
);
    localparam int N      = WORD_SIZE;
    localparam int STAGES = 3;
    // k >= N-2 and k <= -(N-2) saturate; unsigned compares are valid once
    // the sign of k is known.
    localparam logic [RS:0] K_MAX = (RS+1)'(N - 2);
    localparam logic [RS:0] K_MIN = (RS+1)'(2 - N);

    logic               en;
    logic [STAGES:1]    vld_pipe;

    assign en        = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    // ---------------- stage 1: regime run and field packing ----------------
    logic                  neg_k, sat_hi, sat_lo;
    logic [RS:0]           shamt;
    logic signed [2*N-1:0] base, run;
    logic [N-2:0]          body_c;
    logic                  guard_c, sticky_c;

    // Seed the shortest regime (1 then 0, or 0 then 1) and arithmetic-shift
    // by r-1 to stretch the run; the low half catches guard and sticky bits.
    always_comb begin
        neg_k    = in_regime[RS];
        sat_hi   = !neg_k && (in_regime >= K_MAX);
        sat_lo   = neg_k && (in_regime <= K_MIN);
        shamt    = neg_k ? ~in_regime : in_regime;
        base     = {(neg_k ? 2'b01 : 2'b10), in_exp, in_frac, {(N-2){1'b0}}};
        run      = base >>> shamt;
        body_c   = run[2*N-1 -: N-1];
        guard_c  = run[N];
        sticky_c = |run[N-1:0];
        if (sat_hi) begin
            body_c   = '1;
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end else if (sat_lo) begin
            body_c   = (N-1)'(1);
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end
    end

    logic [N-2:0] s1_body;
    logic         s1_guard, s1_sticky, s1_sign, s1_zero, s1_nar;

    // ---------------- stage 2: round to nearest, ties to even ----------------
    logic         round_up;
    logic [N-2:0] body_r;

    // An all-ones body would carry into the NaR pattern, so it stays at maxpos.
    always_comb begin
        round_up = s1_guard && (s1_sticky || s1_body[0]);
        body_r   = s1_body;
        if (round_up && !(&s1_body))
            body_r = s1_body + (N-1)'(1);
    end

    logic [N-2:0] s2_body;
    logic         s2_sign, s2_zero, s2_nar;

    // ---------------- stage 3: sign and special values ----------------
    logic [N-1:0] word;

    // NaR beats zero, and both ignore the sign.
    always_comb begin
        word = {1'b0, s2_body};
        if (s2_sign)
            word = ~word + N'(1);
        if (s2_nar)
            word = {1'b1, {(N-1){1'b0}}};
        else if (s2_zero)
            word = '0;
    end

    // Valid shift register; bubbles move with the data and are not squeezed out.
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // Data stages advance with the valid bits; no reset needed on payload.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_body   <= body_c;
            s1_guard  <= guard_c;
            s1_sticky <= sticky_c;
            s1_sign   <= in_sign;
            s1_zero   <= in_zero;
            s1_nar    <= in_nar;
            s2_body   <= body_r;
            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero;
            s2_nar    <= s1_nar;
        end
    end

    // Output word register, cleared on reset and held while stalled.
    always_ff @(posedge clk) begin
        if (rst)
            out_posit <= '0;
        else if (en)
            out_posit <= word;
    end
endmodule

// File: tb/tb_posit_pack.sv
// tb_posit_pack: directed vectors with hand-computed posit<32,2> encodings,
// single-beat latency checks, a backpressured stream and a mid-flight reset.
module tb_posit_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign, in_zero, in_nar;
    logic [5:0]  in_regime;
    logic [1:0]  in_exp;
    logic [29:0] in_frac;
    logic        out_valid, out_ready;
    logic [31:0] out_posit;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        s, z, n;
        logic [5:0]  k;
        logic [1:0]  e;
        logic [29:0] f;
        logic [31:0] x;
    } vec_t;

    vec_t tv[$];

    posit_pack #(.WORD_SIZE(32), .RS(5), .ES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar),
        .in_regime(in_regime), .in_exp(in_exp), .in_frac(in_frac),
        .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, z, n, input logic [5:0] k,
                                input logic [1:0] e, input logic [29:0] f,
                                input logic [31:0] x);
        vec_t v;
        v.s = s; v.z = z; v.n = n; v.k = k; v.e = e; v.f = f; v.x = x;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_sign   = v.s;
        in_zero   = v.z;
        in_nar    = v.n;
        in_regime = v.k;
        in_exp    = v.e;
        in_frac   = v.f;
    endtask

    initial begin
        //       s     z     n     k       e      f              expected
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 30'h0,        32'h40000000)); // 1.0
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 6'd0,  2'd0, 30'h0,        32'hC0000000)); // -1.0
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'd1,  2'd1, 30'h0,        32'h64000000)); // 32
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 6'd5,  2'd2, 30'h123,      32'h00000000)); // zero
        tv.push_back(mk(1'b1, 1'b1, 1'b1, 6'd3,  2'd1, 30'h55,       32'h80000000)); // NaR over zero
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'd31, 2'd0, 30'h0,        32'h7FFFFFFF)); // maxpos
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'h20, 2'd0, 30'h0,        32'h00000001)); // minpos
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 6'h20, 2'd0, 30'h0,        32'hFFFFFFFF)); // -minpos
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 30'h4,        32'h40000000)); // tie, even
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 30'hC,        32'h40000002)); // tie, odd
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 30'h5,        32'h40000001)); // above half
        // k=29 fills the body with 111..10; exp=3 puts a 1 in the guard -> up to maxpos
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'd29, 2'd3, 30'h3FFFFFFF, 32'h7FFFFFFF));
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'h3F, 2'd0, 30'h0,        32'h20000000)); // k=-1
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 6'h3F, 2'd0, 30'h0,        32'hE0000000)); // -(k=-1)
        tv.push_back(mk(1'b0, 1'b0, 1'b0, 6'h3D, 2'd2, 30'h0,        32'h0C000000)); // k=-3, e=2
    end

    initial begin
        int sent, recv;
        logic [31:0] prev;
        logic stalled;
        int sid[5];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(tv[0]);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_posit", out_posit, 32'h0);
        rst = 1'b0;

        // Single beats: output appears exactly three edges after acceptance.
        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("lat1_v%0d", i), out_valid, 0);
            @(negedge clk);
            chk($sformatf("lat2_v%0d", i), out_valid, 0);
            @(negedge clk);
            chk($sformatf("lat3_v%0d", i), out_valid, 1);
            chk($sformatf("data_v%0d", i), out_posit, tv[i].x);
            @(negedge clk);
            chk($sformatf("gone_v%0d", i), out_valid, 0);
        end

        // Stream of five with out_ready low in cycles 4..7.
        sid = '{0, 1, 2, 3, 4};
        sent = 0; recv = 0; stalled = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < 5) begin
                drive(tv[sid[sent]]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_in_ready", in_ready, !(out_valid && !out_ready));
            if (stalled) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_posit, prev);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_data%0d", recv), out_posit, tv[sid[recv]].x);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stalled = out_valid && !out_ready;
            prev = out_posit;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", recv, 5);
        repeat (4) begin
            @(negedge clk);
            chk("bp_drain", out_valid, 0);
        end

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(tv[i]);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_posit", out_posit, 32'h0);
        repeat (5) begin
            @(negedge clk);
            chk("mid_rst_stale", out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
